jb_shutdown_sequencer: RTL and testbench

//  Ordered power-down/power-up sequencer for the PA, DAC and PSU shutdown controls in pl_control.
//  - Qualifies shutdown sources: PSU alarm (debounced), RF overdrive, software.
//  - Power-down order: PA -> DAC -> PSU, with a programmable spacing between steps.
//  - Power-up order: PSU -> DAC -> PA, only on software restart when no fault is active.

---
 rtl/jb_shutdown_sequencer.sv | 161 ++++++++++++++++
 tb/tb_jb_shutdown_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jb_shutdown_sequencer.sv
// Ordered PA/DAC/PSU power-down and power-up sequencer with a qualified fault input.
// Optional power-down entry counter is enabled by defining JB_SHDN_EVENT_CNT_EN.
module jb_shutdown_sequencer #(
  parameter int DLY_BW   = 16,
  parameter int DEBOUNCE = 8
) (
  input  logic              clk_15p36,
  input  logic              rst_15p36,
  input  logic              psu_alarm_n,
  input  logic              psu_alarm_enable,
  input  logic              overdrive_alarm,
  input  logic              sw_shutdown,
  input  logic              sw_restart,
  input  logic [DLY_BW-1:0] dly_step,
  output logic              pa_shutdown,
  output logic              dac_shutdown,
  output logic              psu_shutdown,
  output logic              seq_busy,
  output logic [2:0]        seq_state,
  output logic [2:0]        shdn_cause,
  output logic [15:0]       shdn_event_cnt
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE);
  localparam logic [DLY_BW-1:0] ONE = DLY_BW'(1);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    PA_OFF  = 3'd1,
    DAC_OFF = 3'd2,
    SHDN    = 3'd3,
    UP_PSU  = 3'd4,
    UP_DAC  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        sync_q;
  logic [CW-1:0]     deb_q, deb_d;
  logic [DLY_BW-1:0] tmr_q, tmr_d;
  logic              pa_off_q, pa_off_d;
  logic              dac_off_q, dac_off_d;
  logic              psu_off_q, psu_off_d;
  logic [2:0]        cause_q, cause_d;
  logic              psu_flt, fault, tmr_done;
  logic [DLY_BW-1:0] step_ld;

  // Alarm idles high, so the synchroniser resets to the inactive level
  always_ff @(posedge clk_15p36 or posedge rst_15p36) begin
    if (rst_15p36) begin
      sync_q <= 2'b11;
      deb_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], psu_alarm_n};
      deb_q  <= deb_d;
    end
  end

  always_comb begin
    deb_d = deb_q;
    if (sync_q[1])
      deb_d = '0;
    else if (deb_q != DEB_MAX)
      deb_d = deb_q + 1'b1;
  end

  assign psu_flt  = psu_alarm_enable && (deb_q == DEB_MAX);
  assign fault    = psu_flt || overdrive_alarm || sw_shutdown;
  assign step_ld  = (dly_step == '0) ? ONE : dly_step;
  assign tmr_done = (tmr_q <= ONE);

  always_ff @(posedge clk_15p36 or posedge rst_15p36) begin
    if (rst_15p36) begin
      state_q   <= SHDN;
      tmr_q     <= ONE;
      pa_off_q  <= 1'b1;
      dac_off_q <= 1'b1;
      psu_off_q <= 1'b1;
      cause_q   <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      pa_off_q  <= pa_off_d;
      dac_off_q <= dac_off_d;
      psu_off_q <= psu_off_d;
      cause_q   <= cause_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pa_off_d  = pa_off_q;
    dac_off_d = dac_off_q;
    psu_off_d = psu_off_q;
    cause_d   = cause_q;
    tmr_d     = tmr_done ? tmr_q : tmr_q - ONE;
    unique case (state_q)
      RUN:     if (fault) state_d = PA_OFF;
      PA_OFF:  if (tmr_done) state_d = DAC_OFF;
      DAC_OFF: if (tmr_done) state_d = SHDN;
      SHDN:    if (sw_restart && !fault) state_d = UP_PSU;
      UP_PSU:  begin
        if (fault)         state_d = PA_OFF;
        else if (tmr_done) state_d = UP_DAC;
      end
      UP_DAC:  begin
        if (fault)         state_d = PA_OFF;
        else if (tmr_done) state_d = RUN;
      end
      default: state_d = SHDN;
    endcase
    // Each entry moves exactly one rail; an abort leaves dac/psu where they were
    if (state_d != state_q) begin
      tmr_d = step_ld;
      case (state_d)
        PA_OFF: begin
          pa_off_d = 1'b1;
          cause_d  = {sw_shutdown, overdrive_alarm, psu_flt};
        end
        DAC_OFF: dac_off_d = 1'b1;
        UP_PSU: begin
          psu_off_d = 1'b0;
          cause_d   = '0;
        end
        UP_DAC:  dac_off_d = 1'b0;
        RUN:     pa_off_d  = 1'b0;
        default: begin
          pa_off_d  = 1'b1;
          dac_off_d = 1'b1;
          psu_off_d = 1'b1;
        end
      endcase
    end
  end

  assign pa_shutdown  = pa_off_q;
  assign dac_shutdown = dac_off_q;
  assign psu_shutdown = psu_off_q;
  assign seq_state    = state_q;
  assign shdn_cause   = cause_q;
  assign seq_busy     = (state_q != RUN) && (state_q != SHDN);

`ifdef JB_SHDN_EVENT_CNT_EN
  logic        enter_pa;
  logic [15:0] evt_q;

  assign enter_pa = (state_d == PA_OFF) && (state_q != PA_OFF);

  always_ff @(posedge clk_15p36 or posedge rst_15p36) begin
    if (rst_15p36)
      evt_q <= '0;
    else if (enter_pa && (evt_q != 16'hFFFF))
      evt_q <= evt_q + 16'd1;
  end

  assign shdn_event_cnt = evt_q;
`else
  assign shdn_event_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_jb_shutdown_sequencer.sv
// Bench for jb_shutdown_sequencer: vector table, directed corner sequences,
// and random stimulus against a rail-list reference model.
module tb_jb_shutdown_sequencer;
  localparam int DEB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alarm_n = 1'b1;
  logic        alarm_en = 1'b0;
  logic        od = 1'b0;
  logic        sw = 1'b0;
  logic        rs = 1'b0;
  logic [15:0] dly = 16'd1;
  logic        pa, dac, psu, busy;
  logic [2:0]  st, cause;
  logic [15:0] evt;

  int checks = 0;
  int errors = 0;
  bit mchk = 0;

  jb_shutdown_sequencer #(.DLY_BW(16), .DEBOUNCE(DEB)) dut (
    .clk_15p36(clk),
    .rst_15p36(rst),
    .psu_alarm_n(alarm_n),
    .psu_alarm_enable(alarm_en),
    .overdrive_alarm(od),
    .sw_shutdown(sw),
    .sw_restart(rs),
    .dly_step(dly),
    .pa_shutdown(pa),
    .dac_shutdown(dac),
    .psu_shutdown(psu),
    .seq_busy(busy),
    .seq_state(st),
    .shdn_cause(cause),
    .shdn_event_cnt(evt)
  );

  always #5 clk = ~clk;

  // Reference: mode 0 run, 1 going down, 2 all off, 3 going up.
  // m_next counts rails already moved in the current direction.
  int          m_mode, m_next, m_wait, m_evt;
  bit          m_off[3];
  logic [2:0]  m_cause;
  bit          al_q[$];

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic void model_reset();
    m_mode = 2; m_next = 0; m_wait = 0; m_evt = 0;
    m_off[0] = 1; m_off[1] = 1; m_off[2] = 1;
    m_cause = 3'b000;
    al_q = {};
    repeat (3) al_q.push_back(1'b1);
  endfunction

  function automatic logic [2:0] m_state();
    case (m_mode)
      0: return 3'd0;
      1: return 3'(m_next);
      2: return 3'd3;
      default: return (m_next == 1) ? 3'd4 : 3'd5;
    endcase
  endfunction

  function automatic void model_edge();
    int run = 0;
    int sp = (dly == 0) ? 1 : int'(dly);
    bit q, f;
    // Alarm seen by the sequencer lags the pin by the sync and count stages
    for (int i = al_q.size() - 3; i >= 0; i--) begin
      if (al_q[i] || run >= DEB) break;
      run++;
    end
    q = alarm_en && (run >= DEB);
    f = q || od || sw;
    if ((m_mode == 0 || m_mode == 3) && f) begin
      m_off[0] = 1; m_mode = 1; m_next = 1; m_wait = sp;
      m_cause = {sw, od, q}; m_evt++;
    end else if (m_mode == 1 || m_mode == 3) begin
      m_wait--;
      if (m_wait == 0) begin
        if (m_mode == 1) m_off[m_next] = 1;
        else m_off[2 - m_next] = 0;
        m_next++;
        if (m_next == 3) m_mode = (m_mode == 1) ? 2 : 0;
        else m_wait = sp;
      end
    end else if (m_mode == 2 && rs && !f) begin
      m_off[2] = 0; m_mode = 3; m_next = 1; m_wait = sp;
      m_cause = 3'b000;
    end
    al_q.push_back(alarm_n);
    if (al_q.size() > 40) void'(al_q.pop_front());
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    rs = 1'b0;
    if (mchk)
      chk("model", {st, pa, dac, psu, busy, cause},
          {m_state(), m_off[0], m_off[1], m_off[2],
           (m_mode == 1 || m_mode == 3), m_cause});
  endtask

  task automatic do_reset();
    rst = 1'b1; od = 0; sw = 0; rs = 0; alarm_n = 1; alarm_en = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (st !== s && n < budget) begin
      step();
      n++;
    end
    chk("wait_state", st, s);
  endtask

  task automatic power_up();
    rs = 1'b1;
    step();
    wait_state(3'd0, 200);
  endtask

  typedef struct {
    bit         od;
    bit         sw;
    bit         rs;
    logic [2:0] st;
    logic [2:0] off;
    bit         busy;
  } vec_t;

  vec_t tv[18];
  logic [15:0] exp_evt;

  initial begin
    tv[0]  = '{0, 0, 1, 3'd4, 3'b110, 1};
    tv[1]  = '{0, 0, 0, 3'd4, 3'b110, 1};
    tv[2]  = '{0, 0, 0, 3'd5, 3'b100, 1};
    tv[3]  = '{0, 0, 0, 3'd5, 3'b100, 1};
    tv[4]  = '{0, 0, 0, 3'd0, 3'b000, 0};
    tv[5]  = '{1, 0, 0, 3'd1, 3'b100, 1};
    tv[6]  = '{0, 0, 1, 3'd1, 3'b100, 1};
    tv[7]  = '{0, 0, 0, 3'd2, 3'b110, 1};
    tv[8]  = '{0, 0, 0, 3'd2, 3'b110, 1};
    tv[9]  = '{0, 0, 0, 3'd3, 3'b111, 0};
    tv[10] = '{0, 1, 1, 3'd3, 3'b111, 0};
    tv[11] = '{0, 0, 1, 3'd4, 3'b110, 1};
    tv[12] = '{0, 0, 0, 3'd4, 3'b110, 1};
    tv[13] = '{1, 0, 0, 3'd1, 3'b110, 1};
    tv[14] = '{0, 0, 0, 3'd1, 3'b110, 1};
    tv[15] = '{0, 0, 0, 3'd2, 3'b110, 1};
    tv[16] = '{0, 0, 0, 3'd2, 3'b110, 1};
    tv[17] = '{0, 0, 0, 3'd3, 3'b111, 0};

    // Reset state and idle hold
    do_reset();
    chk("rst_outs", {pa, dac, psu, busy, st, cause}, {3'b111, 1'b0, 3'd3, 3'd0});
    chk("rst_evt", evt, 16'd0);
    repeat (5) step();
    chk("idle_shdn", {st, pa, dac, psu}, {3'd3, 3'b111});

    // Vector table, dly_step=2
    dly = 16'd2;
    for (int i = 0; i < 18; i++) begin
      od = tv[i].od; sw = tv[i].sw; rs = tv[i].rs;
      step();
      chk($sformatf("vec%0d", i), {st, pa, dac, psu, busy},
          {tv[i].st, tv[i].off, tv[i].busy});
    end
    od = 0; sw = 0;
    chk("vec_cause", cause, 3'b010);

    // Power-up spacing with dly_step=10
    dly = 16'd10;
    rs = 1'b1;
    step();
    chk("up_t1", {psu, dac, pa}, 3'b011);
    repeat (9) step();
    chk("up_t10", dac, 1'b1);
    step();
    chk("up_t11", {dac, pa}, 2'b01);
    repeat (9) step();
    chk("up_t20", {pa, busy}, 2'b11);
    step();
    chk("up_t21", {pa, busy, st}, {2'b00, 3'd0});

    // Overdrive power-down with dly_step=5
    dly = 16'd5;
    od = 1'b1;
    step();
    od = 1'b0;
    chk("od_t1", {pa, dac, cause}, {2'b10, 3'b010});
    repeat (4) step();
    chk("od_t5", dac, 1'b0);
    step();
    chk("od_t6", {dac, psu}, 2'b10);
    repeat (4) step();
    chk("od_t10", psu, 1'b0);
    step();
    chk("od_t11", {psu, st}, {1'b1, 3'd3});

    // PSU alarm debounce: 7-cycle glitch, then 8-cycle low
    dly = 16'd1;
    power_up();
    alarm_en = 1'b1;
    alarm_n = 1'b0;
    repeat (7) step();
    alarm_n = 1'b1;
    repeat (12) step();
    chk("deb_glitch7", {st, pa}, {3'd0, 1'b0});
    alarm_n = 1'b0;
    repeat (8) step();
    alarm_n = 1'b1;
    repeat (2) step();
    chk("deb_pre", pa, 1'b0);
    step();
    chk("deb_qual", {pa, st, cause}, {1'b1, 3'd1, 3'b001});
    wait_state(3'd3, 50);
    power_up();
    alarm_en = 1'b0;
    alarm_n = 1'b0;
    repeat (12) step();
    alarm_n = 1'b1;
    repeat (4) step();
    chk("deb_disabled", {st, pa}, {3'd0, 1'b0});

    // Abort from UP_DAC, then restart refused while fault held
    sw = 1'b1;
    step();
    sw = 1'b0;
    wait_state(3'd3, 50);
    dly = 16'd4;
    rs = 1'b1;
    step();
    repeat (4) step();
    chk("ab_updac", {st, dac, psu}, {3'd5, 2'b00});
    od = 1'b1;
    step();
    chk("ab_entry", {st, pa, dac, psu, cause}, {3'd1, 3'b100, 3'b010});
    repeat (3) step();
    chk("ab_hold", dac, 1'b0);
    step();
    chk("ab_dac", {st, dac}, {3'd2, 1'b1});
    wait_state(3'd3, 50);
    rs = 1'b1;
    step();
    chk("ab_rs_ign", {st, psu}, {3'd3, 1'b1});
    od = 1'b0;

    // dly_step=0 behaves as 1-cycle spacing; three power-downs
    do_reset();
    dly = 16'd0;
    for (int k = 0; k < 3; k++) begin
      rs = 1'b1;
      step();
      chk("z_up1", {st, psu}, {3'd4, 1'b0});
      step();
      chk("z_up2", {st, dac}, {3'd5, 1'b0});
      step();
      chk("z_run", {st, pa}, {3'd0, 1'b0});
      sw = 1'b1;
      step();
      sw = 1'b0;
      chk("z_dn1", {st, pa}, {3'd1, 1'b1});
      step();
      chk("z_dn2", {st, dac}, {3'd2, 1'b1});
      step();
      chk("z_dn3", {st, psu}, {3'd3, 1'b1});
    end
`ifdef JB_SHDN_EVENT_CNT_EN
    exp_evt = 16'd3;
`else
    exp_evt = 16'd0;
`endif
    chk("evt_cnt", evt, exp_evt);

    // Randomised run against the reference model
    do_reset();
    mchk = 1;
    for (int c = 0; c < 3000; c++) begin
      od = ($urandom_range(0, 99) < 2);
      if (sw) sw = ($urandom_range(0, 99) >= 10);
      else    sw = ($urandom_range(0, 99) < 1);
      rs = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 99) < 8) alarm_n = ~alarm_n;
      if ($urandom_range(0, 99) < 1) alarm_en = ~alarm_en;
      dly = 16'($urandom_range(0, 3));
      step();
      chk("inv_order", (pa >= dac) && (dac >= psu), 1'b1);
    end
    mchk = 0;
`ifdef JB_SHDN_EVENT_CNT_EN
    exp_evt = 16'(m_evt);
`else
    exp_evt = 16'd0;
`endif
    chk("rand_evt", evt, exp_evt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
